// File: rtl/ex_stage.sv
// Execute stage: ID/EX and EX/MEM banks, 32-bit ALU, and a request/wait data-memory handshake.
// Results write back two cycles after decode; memStall freezes both banks while an access is outstanding.
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_instruction,
  input  logic [31:0] id_pcPlus4,
  input  logic        id_isJumpAndLink,
  input  logic        id_shouldWriteRegister,
  input  logic        id_shouldWriteMemoryElseAluOutputToRegister,
  input  logic        id_shouldWriteToRegisterRtElseRd,
  input  logic        id_shouldWriteMemory,
  input  logic        id_shouldAluUseShiftAmountElseRegisterA,
  input  logic        id_shouldAluUseImmeidateElseRegisterB,
  input  logic [4:0]  id_aluOperation,
  input  logic [31:0] id_immediate,
  input  logic [31:0] id_registerRs,
  input  logic [31:0] id_registerRt,
  input  logic        id_shouldStall,
  output logic [31:0] ex_instruction,
  output logic [31:0] ex_aluResult,
  output logic        memRequest,
  output logic        memWrite,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic        memReady,
  input  logic [31:0] memReadData,
  output logic        memStall,
  output logic        mem_shouldWriteRegister,
  output logic [4:0]  mem_registerWriteAddress,
  output logic [31:0] mem_registerWriteData
);

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        jal;
    logic        wreg;
    logic        m2reg;
    logic        rt_dst;
    logic        wmem;
    logic        shamt_sel;
    logic        imm_sel;
    logic [4:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wa;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
  } exmem_t;

  typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

  idex_t      idex_q, idex_d, idex_in;
  exmem_t     exmem_q, exmem_d;
  mem_state_t state_q, state_d;

  logic [31:0] op_a, op_b, alu_out;
  logic [4:0]  shamt, ex_wa;
  logic        mem_op;

  always_comb begin
    idex_in             = '0;
    idex_in.instruction = id_instruction;
    idex_in.pc_plus4    = id_pcPlus4;
    idex_in.jal         = id_isJumpAndLink;
    idex_in.wreg        = id_shouldWriteRegister;
    idex_in.m2reg       = id_shouldWriteMemoryElseAluOutputToRegister;
    idex_in.rt_dst      = id_shouldWriteToRegisterRtElseRd;
    idex_in.wmem        = id_shouldWriteMemory;
    idex_in.shamt_sel   = id_shouldAluUseShiftAmountElseRegisterA;
    idex_in.imm_sel     = id_shouldAluUseImmeidateElseRegisterB;
    idex_in.alu_op      = id_aluOperation;
    idex_in.imm         = id_immediate;
    idex_in.rs          = id_registerRs;
    idex_in.rt          = id_registerRt;
  end

  always_comb begin
    op_a  = idex_q.shamt_sel ? {27'b0, idex_q.instruction[10:6]} : idex_q.rs;
    op_b  = idex_q.imm_sel ? idex_q.imm : idex_q.rt;
    shamt = op_a[4:0];
    case (idex_q.alu_op)
      5'd0:    alu_out = op_a + op_b;
      5'd1:    alu_out = op_a - op_b;
      5'd2:    alu_out = op_a & op_b;
      5'd3:    alu_out = op_a | op_b;
      5'd4:    alu_out = op_a ^ op_b;
      5'd5:    alu_out = ~(op_a | op_b);
      5'd6:    alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
      5'd7:    alu_out = {31'b0, op_a < op_b};
      5'd8:    alu_out = op_b << shamt;
      5'd9:    alu_out = op_b >> shamt;
      5'd10:   alu_out = $signed(op_b) >>> shamt;
      5'd11:   alu_out = op_b << 16;
      default: alu_out = '0;
    endcase
    ex_aluResult = idex_q.jal ? idex_q.pc_plus4 : alu_out;
    if (idex_q.jal)         ex_wa = 5'd31;
    else if (idex_q.rt_dst) ex_wa = idex_q.instruction[20:16];
    else                    ex_wa = idex_q.instruction[15:11];
  end

  // memReady is only looked at in S_WAIT; the request cycle always stalls.
  always_comb begin
    mem_op     = exmem_q.m2reg | exmem_q.wmem;
    memRequest = 1'b0;
    memStall   = 1'b0;
    state_d    = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          memRequest = 1'b1;
          memStall   = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        memStall = ~memReady;
        if (memReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    if (!memStall) begin
      exmem_d.alu   = ex_aluResult;
      exmem_d.rt    = idex_q.rt;
      exmem_d.wa    = ex_wa;
      exmem_d.wreg  = idex_q.wreg;
      exmem_d.m2reg = idex_q.m2reg;
      exmem_d.wmem  = idex_q.wmem;
      idex_d        = id_shouldStall ? '0 : idex_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      state_q <= S_IDLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      state_q <= state_d;
    end
  end

  assign ex_instruction           = idex_q.instruction;
  assign memWrite                 = exmem_q.wmem;
  assign memAddress               = exmem_q.alu;
  assign memWriteData             = exmem_q.rt;
  assign mem_shouldWriteRegister  = exmem_q.wreg & ~memStall & (exmem_q.wa != 5'd0);
  assign mem_registerWriteAddress = exmem_q.wa;
  assign mem_registerWriteData    = exmem_q.m2reg ? memReadData : exmem_q.alu;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level pipeline model.
module tb_ex_stage;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] id_instruction, id_pcPlus4, id_immediate, id_registerRs, id_registerRt;
  logic        id_isJumpAndLink, id_shouldWriteRegister, id_shouldWriteMemoryElseAluOutputToRegister;
  logic        id_shouldWriteToRegisterRtElseRd, id_shouldWriteMemory;
  logic        id_shouldAluUseShiftAmountElseRegisterA, id_shouldAluUseImmeidateElseRegisterB;
  logic [4:0]  id_aluOperation;
  logic        id_shouldStall;
  logic [31:0] ex_instruction, ex_aluResult, memAddress, memWriteData, memReadData;
  logic        memRequest, memWrite, memReady, memStall, mem_shouldWriteRegister;
  logic [4:0]  mem_registerWriteAddress;
  logic [31:0] mem_registerWriteData;

  ex_stage dut (
    .clock(clock), .reset(reset),
    .id_instruction(id_instruction), .id_pcPlus4(id_pcPlus4),
    .id_isJumpAndLink(id_isJumpAndLink), .id_shouldWriteRegister(id_shouldWriteRegister),
    .id_shouldWriteMemoryElseAluOutputToRegister(id_shouldWriteMemoryElseAluOutputToRegister),
    .id_shouldWriteToRegisterRtElseRd(id_shouldWriteToRegisterRtElseRd),
    .id_shouldWriteMemory(id_shouldWriteMemory),
    .id_shouldAluUseShiftAmountElseRegisterA(id_shouldAluUseShiftAmountElseRegisterA),
    .id_shouldAluUseImmeidateElseRegisterB(id_shouldAluUseImmeidateElseRegisterB),
    .id_aluOperation(id_aluOperation), .id_immediate(id_immediate),
    .id_registerRs(id_registerRs), .id_registerRt(id_registerRt),
    .id_shouldStall(id_shouldStall),
    .ex_instruction(ex_instruction), .ex_aluResult(ex_aluResult),
    .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReady(memReady), .memReadData(memReadData),
    .memStall(memStall), .mem_shouldWriteRegister(mem_shouldWriteRegister),
    .mem_registerWriteAddress(mem_registerWriteAddress),
    .mem_registerWriteData(mem_registerWriteData)
  );

  typedef struct {
    logic [31:0] instr, pc4, imm, rs, rt;
    logic        jal, wreg, m2reg, rtdst, wmem, sh, im;
    logic [4:0]  op;
  } dec_t;

  typedef struct {
    logic [31:0] res, st;
    logic [4:0]  wa;
    logic        wreg, m2reg, wmem;
  } mem_t;

  dec_t m_ex;
  mem_t m_mem;
  bit   m_busy;
  int   total = 0;
  int   bad = 0;

  localparam logic [31:0] I_LW  = {6'h23, 5'd1, 5'd9, 16'h0100};
  localparam logic [31:0] I_SW  = {6'h2b, 5'd1, 5'd4, 16'h0020};
  localparam logic [31:0] I_JAL = {6'h03, 26'h10};

  function automatic logic [31:0] r_add(input logic [4:0] rd);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, 6'h20};
  endfunction

  function automatic dec_t zero_dec();
    dec_t d;
    d.instr = 0; d.pc4 = 0; d.imm = 0; d.rs = 0; d.rt = 0;
    d.jal = 0; d.wreg = 0; d.m2reg = 0; d.rtdst = 0; d.wmem = 0; d.sh = 0; d.im = 0; d.op = 0;
    return d;
  endfunction

  function automatic logic [31:0] alu_model(input dec_t d);
    logic [31:0] a, b;
    int unsigned s;
    if (d.jal) return d.pc4;
    a = d.sh ? 32'(d.instr[10:6]) : d.rs;
    b = d.im ? d.imm : d.rt;
    s = a % 32;
    case (d.op)
      0:  return a + b;
      1:  return a + ~b + 1;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~a & ~b;
      6:  return (a[31] != b[31]) ? 32'(a[31]) : 32'(a < b);
      7:  return 32'(a < b);
      8:  return b * (32'd1 << s);
      9:  return b / (32'd1 << s);
      10: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      11: return {b[15:0], 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] wa_model(input dec_t d);
    if (d.jal) return 5'd31;
    return d.rtdst ? d.instr[20:16] : d.instr[15:11];
  endfunction

  function automatic bit model_stall();
    if (m_busy) return !memReady;
    return m_mem.m2reg || m_mem.wmem;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit st, rq, wr;
    st = model_stall();
    rq = !m_busy && (m_mem.m2reg || m_mem.wmem);
    wr = m_mem.wreg && !st && (m_mem.wa != 0);
    chk("m_ex_instr", ex_instruction, m_ex.instr);
    chk("m_ex_alu", ex_aluResult, alu_model(m_ex));
    chk("m_stall", 32'(memStall), 32'(st));
    chk("m_req", 32'(memRequest), 32'(rq));
    chk("m_mwrite", 32'(memWrite), 32'(m_mem.wmem));
    chk("m_maddr", memAddress, m_mem.res);
    chk("m_mwdata", memWriteData, m_mem.st);
    chk("m_rfwe", 32'(mem_shouldWriteRegister), 32'(wr));
    if (wr) begin
      chk("m_rfwa", 32'(mem_registerWriteAddress), 32'(m_mem.wa));
      chk("m_rfwd", mem_registerWriteData, m_mem.m2reg ? memReadData : m_mem.res);
    end
  endtask

  task automatic model_step();
    bit st;
    dec_t d;
    st = model_stall();
    if (reset) begin
      m_ex = zero_dec();
      m_mem = '{default: 0};
      m_busy = 0;
    end else begin
      if (!m_busy && (m_mem.m2reg || m_mem.wmem)) m_busy = 1;
      else if (m_busy && memReady) m_busy = 0;
      if (!st) begin
        m_mem.res = alu_model(m_ex); m_mem.st = m_ex.rt; m_mem.wa = wa_model(m_ex);
        m_mem.wreg = m_ex.wreg; m_mem.m2reg = m_ex.m2reg; m_mem.wmem = m_ex.wmem;
        d.instr = id_instruction; d.pc4 = id_pcPlus4; d.imm = id_immediate;
        d.rs = id_registerRs; d.rt = id_registerRt; d.jal = id_isJumpAndLink;
        d.wreg = id_shouldWriteRegister; d.m2reg = id_shouldWriteMemoryElseAluOutputToRegister;
        d.rtdst = id_shouldWriteToRegisterRtElseRd; d.wmem = id_shouldWriteMemory;
        d.sh = id_shouldAluUseShiftAmountElseRegisterA; d.im = id_shouldAluUseImmeidateElseRegisterB;
        d.op = id_aluOperation;
        m_ex = id_shouldStall ? zero_dec() : d;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clock);
    check_all();
  endtask

  task automatic advance();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc();
    at_neg();
    advance();
  endtask

  task automatic drive_op(input logic [31:0] ins, pc4, imm, rs, rt, input logic [4:0] op,
                          input logic jal, wreg, m2reg, rtdst, wmem, sh, im);
    id_instruction = ins; id_pcPlus4 = pc4; id_immediate = imm;
    id_registerRs = rs; id_registerRt = rt; id_aluOperation = op;
    id_isJumpAndLink = jal; id_shouldWriteRegister = wreg;
    id_shouldWriteMemoryElseAluOutputToRegister = m2reg;
    id_shouldWriteToRegisterRtElseRd = rtdst; id_shouldWriteMemory = wmem;
    id_shouldAluUseShiftAmountElseRegisterA = sh; id_shouldAluUseImmeidateElseRegisterB = im;
    id_shouldStall = 0;
  endtask

  task automatic drive_nop();
    drive_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    memReady = 0;
    memReadData = $urandom;
  endtask

  logic [4:0]  t_op  [8];
  logic [31:0] t_ins [8];
  logic [31:0] t_a   [8];
  logic [31:0] t_b   [8];
  logic        t_sh  [8];
  logic [31:0] t_exp [8];

  initial begin
    int stalls, reqs;
    t_op  = '{5'd10, 5'd6, 5'd7, 5'd11, 5'd5, 5'd1, 5'd20, 5'd8};
    t_ins = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_00C0};
    t_a   = '{32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0F0F_0F0F, 32'd3, 32'd1, 32'h0};
    t_b   = '{32'h8000_0000, 32'd1, 32'd1, 32'h1234, 32'hF0F0_F0F0, 32'd5, 32'd1, 32'd1};
    t_sh  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_exp = '{32'hF800_0000, 32'd1, 32'd0, 32'h1234_0000, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'd8};

    reset = 1;
    drive_nop();
    advance();
    advance();
    reset = 0;
    at_neg();
    chk("rst_stall", 32'(memStall), 0);
    chk("rst_req", 32'(memRequest), 0);
    chk("rst_rfwe", 32'(mem_shouldWriteRegister), 0);
    chk("rst_ex_instr", ex_instruction, 0);
    advance();

    // ADD rs=5 rt=7 rd=3
    drive_op(r_add(3), 32'h4, 0, 5, 7, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc();
    drive_nop();
    at_neg(); chk("add_ex_alu", ex_aluResult, 12); advance();
    at_neg();
    chk("add_rfwe", 32'(mem_shouldWriteRegister), 1);
    chk("add_rfwa", 32'(mem_registerWriteAddress), 3);
    chk("add_rfwd", mem_registerWriteData, 12);
    chk("add_stall", 32'(memStall), 0);
    advance();

    // ALU table
    for (int i = 0; i < 8; i++) begin
      drive_op(t_ins[i], 0, t_b[i], t_a[i], t_b[i], t_op[i], 0, 0, 0, 0, 0, t_sh[i], 0);
      cyc();
      at_neg(); chk($sformatf("alu_tbl%0d", i), ex_aluResult, t_exp[i]); advance();
    end
    drive_nop(); cyc(); cyc();

    // LW 0x100, ready after three waiting cycles
    drive_op(I_LW, 0, 32'h100, 0, 32'h1234, 0, 0, 1, 1, 1, 0, 0, 1);
    cyc();
    drive_nop(); cyc();
    stalls = 0; reqs = 0;
    at_neg();
    chk("lw_req", 32'(memRequest), 1);
    chk("lw_addr", memAddress, 32'h100);
    chk("lw_mwrite", 32'(memWrite), 0);
    stalls += int'(memStall); reqs += int'(memRequest);
    advance();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("lw_wait_rfwe", 32'(mem_shouldWriteRegister), 0);
      stalls += int'(memStall); reqs += int'(memRequest);
      advance();
    end
    memReady = 1; memReadData = 32'hDEAD_BEEF;
    at_neg();
    chk("lw_rdy_stall", 32'(memStall), 0);
    chk("lw_rfwe", 32'(mem_shouldWriteRegister), 1);
    chk("lw_rfwa", 32'(mem_registerWriteAddress), 9);
    chk("lw_rfwd", mem_registerWriteData, 32'hDEAD_BEEF);
    advance();
    drive_nop();
    at_neg(); chk("lw_after_rfwe", 32'(mem_shouldWriteRegister), 0); advance();
    chk("lw_stall_cycles", 32'(stalls), 4);
    chk("lw_req_cycles", 32'(reqs), 1);

    // SW 0x55 to 0x20, ready the cycle after the request
    drive_op(I_SW, 0, 32'h20, 0, 32'h55, 0, 0, 0, 0, 1, 1, 0, 1);
    cyc();
    drive_nop(); cyc();
    at_neg();
    chk("sw_req", 32'(memRequest), 1);
    chk("sw_stall", 32'(memStall), 1);
    chk("sw_mwrite", 32'(memWrite), 1);
    chk("sw_mwdata", memWriteData, 32'h55);
    chk("sw_addr", memAddress, 32'h20);
    advance();
    memReady = 1;
    at_neg();
    chk("sw_rdy_stall", 32'(memStall), 0);
    chk("sw_rfwe", 32'(mem_shouldWriteRegister), 0);
    chk("sw_mwdata_hold", memWriteData, 32'h55);
    advance();
    drive_nop(); cyc();

    // One decode stall inside an ADD stream
    drive_op(r_add(1), 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0); cyc();
    drive_op(r_add(2), 0, 0, 2, 2, 0, 0, 1, 0, 0, 0, 0, 0); id_shouldStall = 1; cyc();
    drive_op(r_add(2), 0, 0, 2, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    at_neg();
    chk("bub_ex_instr", ex_instruction, 0);
    chk("bub_prev_rfwe", 32'(mem_shouldWriteRegister), 1);
    chk("bub_prev_rfwa", 32'(mem_registerWriteAddress), 1);
    advance();
    drive_op(r_add(4), 0, 0, 4, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    at_neg();
    chk("bub_rfwe", 32'(mem_shouldWriteRegister), 0);
    chk("bub_next_instr", ex_instruction, r_add(2));
    advance();
    drive_nop(); cyc(); cyc();

    // JAL, then ADD targeting r0
    drive_op(I_JAL, 32'h40, 0, 32'h99, 32'h77, 0, 1, 1, 0, 0, 0, 0, 0); cyc();
    drive_nop();
    at_neg(); chk("jal_ex_alu", ex_aluResult, 32'h40); advance();
    at_neg();
    chk("jal_rfwe", 32'(mem_shouldWriteRegister), 1);
    chk("jal_rfwa", 32'(mem_registerWriteAddress), 31);
    chk("jal_rfwd", mem_registerWriteData, 32'h40);
    advance();
    drive_op(r_add(0), 0, 0, 3, 4, 0, 0, 1, 0, 0, 0, 0, 0); cyc();
    drive_nop(); cyc();
    at_neg(); chk("r0_rfwe", 32'(mem_shouldWriteRegister), 0); advance();

    // Reset while waiting on a load
    drive_op(I_LW, 0, 32'h100, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1); cyc();
    drive_nop(); cyc();
    at_neg(); chk("rw_req", 32'(memRequest), 1); advance();
    at_neg(); chk("rw_wait_stall", 32'(memStall), 1);
    reset = 1;
    advance();
    reset = 0;
    at_neg();
    chk("rw_stall", 32'(memStall), 0);
    chk("rw_req0", 32'(memRequest), 0);
    chk("rw_rfwe", 32'(mem_shouldWriteRegister), 0);
    chk("rw_ex_instr", ex_instruction, 0);
    chk("rw_addr", memAddress, 0);
    advance();
    memReady = 1;
    at_neg();
    chk("rw_late_rdy_stall", 32'(memStall), 0);
    chk("rw_late_rdy_req", 32'(memRequest), 0);
    chk("rw_late_rdy_rfwe", 32'(mem_shouldWriteRegister), 0);
    advance();
    memReady = 0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      id_instruction = $urandom; id_pcPlus4 = $urandom; id_immediate = $urandom;
      id_registerRs = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      id_registerRt = $urandom;
      id_aluOperation = 5'($urandom_range(0, 31));
      id_isJumpAndLink = ($urandom_range(0, 15) == 0);
      id_shouldWriteRegister = ($urandom_range(0, 3) != 0);
      id_shouldWriteMemoryElseAluOutputToRegister = ($urandom_range(0, 6) == 0);
      id_shouldWriteMemory = !id_shouldWriteMemoryElseAluOutputToRegister && ($urandom_range(0, 8) == 0);
      id_shouldWriteToRegisterRtElseRd = 1'($urandom_range(0, 1));
      id_shouldAluUseShiftAmountElseRegisterA = 1'($urandom_range(0, 1));
      id_shouldAluUseImmeidateElseRegisterB = 1'($urandom_range(0, 1));
      id_shouldStall = ($urandom_range(0, 9) == 0);
      memReady = ($urandom_range(0, 2) == 0);
      memReadData = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
